mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Control FSM for the multi-cycle MIPS core; successor to the single-cycle main decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states, sharing one ALU and one unified memory port.
- Memory port uses a req/ready handshake, supports variable wait states, and has a watchdog timeout.
- Covers the full single-cycle opcode set plus illegal-opcode trapping.

Parameters:
- ALUOP_W, 4, width of ALUOp; the encodings below occupy the low 4 bits, and upper bits are 0.
- TIMEOUT, 16, max cycles a memory state waits for mem_ready; 0 disables the watchdog.
- CNT_W, 5, wait-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  instruction[31:26] from the IR, valid from DECODE onward
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- IorD  out  1  0 = address is PC, 1 = address is ALUOut
- IRWrite  out  1  load the IR
- PCWrite  out  1  unconditional PC load
- PCSrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 rt, 01 const 4, 10 imm, 11 imm<<2
- ALUOp  out  ALUOP_W  ALU operation code
- RegWrite, MemWrite, MemToReg, zero_extended, unsigned_ALU_op, immediate_to_upper_reg, PC_to_ra_reg  out  1 each  same meaning as in the single-cycle datapath
- RegDst  out  2  same meaning as in the single-cycle datapath
- MEM_size  out  2  same meaning as in the single-cycle datapath
- Branch  out  3  same meaning as in the single-cycle datapath
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- bus_error  out  1  one-cycle pulse on memory timeout
- state_dbg  out  4  current state encoding

Behaviour:
- One clock domain; reset is synchronous, active-low. At the rising clk edge with rst_n=0: state=FETCH, wait counter=0, latched opcode=0.
- Moore outputs, decoded from the state and the latched opcode op_q. op_q is captured on exit from DECODE.
- Unlisted outputs are 0 in every state.
- During reset, every output is 0 except mem_req=1 and ALUSrcB=01; these are the FETCH values with mem_ready ignored.

State encodings and outputs:
- FETCH(0): mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0000.
  - IRWrite and PCWrite assert only in the cycle mem_ready=1, with PCSrc=00.
  - Holds while mem_ready=0. Goes to DECODE on ready.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=0000 (precomputes branch target). Next state by opcode:
  - 000000 → EXEC
  - 100000/100001/100011/100100/100101/101000/101001/101011 → MEM_ADR
  - 000001/000100-000111 → BRANCH
  - 000010/000011 → JUMP
  - 001000-001111 → IMM_EXEC
  - otherwise → TRAP
- MEM_ADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=0000. Loads go to MEM_RD; stores go to MEM_WR.
- MEM_RD(3): mem_req=1, IorD=1, MEM_size and unsigned_ALU_op per opcode. Waits on mem_ready, then goes to MEM_WB.
- MEM_WB(4): RegWrite=1, MemToReg=1, RegDst=00, MEM_size and unsigned_ALU_op held. Goes to FETCH.
- MEM_WR(5): mem_req=1, IorD=1, MemWrite=1, MEM_size per opcode. Waits on mem_ready, then goes to FETCH.
- EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=1111. Goes to ALU_WB.
- ALU_WB(7): RegWrite=1, RegDst=10. Goes to FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, PCSrc=01. Goes to FETCH.
  - Branch codes: bltz 011, beq 001, bne 010, blez 100, bgtz 101.
  - ALUOp: bltz 0000, beq/bne 0001, blez 0010, bgtz 0011.
- JUMP(9): PCWrite=1, PCSrc=10. Goes to FETCH.
  - For jal (000011) also RegWrite=1, RegDst=10, PC_to_ra_reg=1, ALUOp=0010.
- IMM_EXEC(10): ALUSrcA=1, ALUSrcB=10. Goes to IMM_WB.
  - ALUOp: addi/addiu 0100, slti/sltiu 0101, andi 0110, ori 0111, xori 1000, lui 1000.
  - unsigned_ALU_op for addiu/sltiu. zero_extended for andi/ori/xori. immediate_to_upper_reg for lui.
- IMM_WB(11): IMM_EXEC controls held, plus RegWrite=1, RegDst=00. Goes to FETCH.
- TRAP(12): illegal_op=1 for exactly one cycle, no writes. Goes to FETCH; PC already advanced, so the instruction is skipped.

Watchdog (FETCH, MEM_RD, MEM_WR):
- Counter clears on entry to each memory state and increments each cycle that mem_ready=0.
- If TIMEOUT≠0 and counter==TIMEOUT-1 with mem_ready=0:
  - bus_error pulses that cycle.
  - IRWrite, PCWrite and MemWrite are suppressed that cycle.
  - Next state is FETCH and the counter clears.
- mem_ready=1 in the same cycle as the timeout: ready wins, normal completion, no bus_error.
- Timeout in FETCH refetches the same PC.

Reset mid-instruction: rst_n=0 in any state returns to FETCH on the next edge, with no partial RegWrite/MemWrite in the reset cycle.

CPI with zero wait states: R/imm 4, lw 5, sw 4, branch 3, j/jal 3, illegal 3. Each memory wait cycle adds 1.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then release → state_dbg=0, mem_req=1, RegWrite=MemWrite=0. R-type with mem_ready=1 constantly → state_dbg sequence 0,1,6,7,0; RegWrite=1, RegDst=10 only in cycle 4.
- lw (100011) with FETCH ready at once and MEM_RD ready after 2 wait cycles → states 0,1,2,3,3,3,4,0; IorD=1 and MEM_size=10 during MEM_RD; MemToReg=1 in MEM_WB.
- sw (101011) with TIMEOUT=16, mem_ready held 0 in MEM_WR → bus_error pulses on the 16th MEM_WR cycle with MemWrite=0 that cycle; next state 0.
- Opcode 111111 → states 0,1,12,0; illegal_op high exactly one cycle; no RegWrite/MemWrite/PCWrite after FETCH.
- Sweep bgtz, bltz, jal and lui → bgtz BRANCH: Branch=101, ALUOp=0011, PCSrc=01. bltz: Branch=011. jal JUMP: PCWrite=1, PCSrc=10, PC_to_ra_reg=1, RegWrite=1. lui IMM_WB: immediate_to_upper_reg=1, RegWrite=1.
- rst_n=0 during MEM_WR while mem_ready=0 → next state_dbg=0, MemWrite=0 in the following cycle; counter restarts from 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over one
// ALU and one unified memory port with a req/ready handshake and a watchdog timeout.
module mips_multicycle_ctrl #(
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         PCSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               zero_extended,
    output logic               unsigned_ALU_op,
    output logic               immediate_to_upper_reg,
    output logic               PC_to_ra_reg,
    output logic [1:0]         RegDst,
    output logic [1:0]         MEM_size,
    output logic [2:0]         Branch,
    output logic               illegal_op,
    output logic               bus_error,
    output logic [3:0]         state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADR  = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        ALU_WB   = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        IMM_EXEC = 4'd10,
        IMM_WB   = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam bit               WD_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       op_q;
    logic             mem_state;
    logic             timeout_hit;
    logic [1:0]       lsu_size;
    logic [3:0]       alu_op4;

    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        casez (op)
            6'b000000:                                   nxt = EXEC;
            6'b100000, 6'b100001, 6'b100011, 6'b100100,
            6'b100101, 6'b101000, 6'b101001, 6'b101011:  nxt = MEM_ADR;
            6'b000001, 6'b0001??:                        nxt = BRANCH;
            6'b00001?:                                   nxt = JUMP;
            6'b001???:                                   nxt = IMM_EXEC;
            default:                                     nxt = TRAP;
        endcase
        return nxt;
    endfunction

    assign mem_state   = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign timeout_hit = WD_EN && mem_state && !mem_ready && (cnt == CNT_LAST);
    // byte/half/word follow opcode[1:0] = 00/01/11
    assign lsu_size    = (op_q[1:0] == 2'b11) ? 2'b10 : op_q[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
            cnt   <= '0;
            op_q  <= '0;
        end else begin
            cnt <= '0;
            case (state)
                FETCH: begin
                    if (mem_ready)         state <= DECODE;
                    else if (!timeout_hit) cnt   <= cnt + 1'b1;
                end
                DECODE: begin
                    op_q  <= opcode;
                    state <= decode_next(opcode);
                end
                MEM_ADR:  state <= (op_q[5:3] == 3'b101) ? MEM_WR : MEM_RD;
                MEM_RD: begin
                    if (mem_ready)        state <= MEM_WB;
                    else if (timeout_hit) state <= FETCH;
                    else                  cnt   <= cnt + 1'b1;
                end
                MEM_WR: begin
                    if (mem_ready || timeout_hit) state <= FETCH;
                    else                          cnt   <= cnt + 1'b1;
                end
                EXEC:     state <= ALU_WB;
                IMM_EXEC: state <= IMM_WB;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req                = 1'b0;
        IorD                   = 1'b0;
        IRWrite                = 1'b0;
        PCWrite                = 1'b0;
        PCSrc                  = 2'b00;
        ALUSrcA                = 1'b0;
        ALUSrcB                = 2'b00;
        alu_op4                = 4'b0000;
        RegWrite               = 1'b0;
        MemWrite               = 1'b0;
        MemToReg               = 1'b0;
        zero_extended          = 1'b0;
        unsigned_ALU_op        = 1'b0;
        immediate_to_upper_reg = 1'b0;
        PC_to_ra_reg           = 1'b0;
        RegDst                 = 2'b00;
        MEM_size               = 2'b00;
        Branch                 = 3'b000;
        illegal_op             = 1'b0;
        bus_error              = 1'b0;
        state_dbg              = 4'd0;
        if (!rst_n) begin
            mem_req = 1'b1;
            ALUSrcB = 2'b01;
        end else begin
            state_dbg = state;
            bus_error = timeout_hit;
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE:  ALUSrcB = 2'b11;
                MEM_ADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEM_RD, MEM_WB: begin
                    MEM_size        = lsu_size;
                    unsigned_ALU_op = op_q[2];
                    mem_req         = (state == MEM_RD);
                    IorD            = (state == MEM_RD);
                    RegWrite        = (state == MEM_WB);
                    MemToReg        = (state == MEM_WB);
                end
                MEM_WR: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    MemWrite = !timeout_hit;
                    MEM_size = lsu_size;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    alu_op4 = 4'b1111;
                end
                ALU_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                end
                BRANCH: begin
                    ALUSrcA = 1'b1;
                    PCSrc   = 2'b01;
                    case (op_q[2:0])
                        3'b001:  begin Branch = 3'b011; alu_op4 = 4'b0000; end
                        3'b100:  begin Branch = 3'b001; alu_op4 = 4'b0001; end
                        3'b101:  begin Branch = 3'b010; alu_op4 = 4'b0001; end
                        3'b110:  begin Branch = 3'b100; alu_op4 = 4'b0010; end
                        default: begin Branch = 3'b101; alu_op4 = 4'b0011; end
                    endcase
                end
                JUMP: begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'b10;
                    if (op_q[0]) begin
                        RegWrite     = 1'b1;
                        RegDst       = 2'b10;
                        PC_to_ra_reg = 1'b1;
                        alu_op4      = 4'b0010;
                    end
                end
                IMM_EXEC, IMM_WB: begin
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = 2'b10;
                    RegWrite = (state == IMM_WB);
                    case (op_q[2:0])
                        3'b000:  alu_op4 = 4'b0100;
                        3'b001:  begin alu_op4 = 4'b0100; unsigned_ALU_op = 1'b1; end
                        3'b010:  alu_op4 = 4'b0101;
                        3'b011:  begin alu_op4 = 4'b0101; unsigned_ALU_op = 1'b1; end
                        3'b100:  begin alu_op4 = 4'b0110; zero_extended = 1'b1; end
                        3'b101:  begin alu_op4 = 4'b0111; zero_extended = 1'b1; end
                        3'b110:  begin alu_op4 = 4'b1000; zero_extended = 1'b1; end
                        default: begin alu_op4 = 4'b1000; immediate_to_upper_reg = 1'b1; end
                    endcase
                end
                TRAP:    illegal_op = 1'b1;
                default: ;
            endcase
        end
        ALUOp = ALUOP_W'(alu_op4);
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized scoreboard bench for mips_multicycle_ctrl: a per-instruction reference model
// queues the expected control word of every cycle; a negedge monitor compares the DUT.
module tb_mips_multicycle_ctrl;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;

    logic       mem_req, IorD, IRWrite, PCWrite, ALUSrcA;
    logic [1:0] PCSrc, ALUSrcB, RegDst, MEM_size;
    logic [3:0] ALUOp, state_dbg;
    logic       RegWrite, MemWrite, MemToReg, zero_extended, unsigned_ALU_op;
    logic       immediate_to_upper_reg, PC_to_ra_reg, illegal_op, bus_error;
    logic [2:0] Branch;

    mips_multicycle_ctrl #(.ALUOP_W(4), .TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .zero_extended(zero_extended), .unsigned_ALU_op(unsigned_ALU_op),
        .immediate_to_upper_reg(immediate_to_upper_reg), .PC_to_ra_reg(PC_to_ra_reg),
        .RegDst(RegDst), .MEM_size(MEM_size), .Branch(Branch),
        .illegal_op(illegal_op), .bus_error(bus_error), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, iord, irw, pcw;
        logic [1:0] pcsrc;
        logic       srca;
        logic [1:0] srcb;
        logic [3:0] aop;
        logic       rw, mw, m2r, zx, uns, up, ra;
        logic [1:0] rdst, msize;
        logic [2:0] br;
        logic       ill, berr;
    } exp_t;

    typedef struct packed {
        logic       rst_n;
        logic       rdy;
        logic [5:0] op;
        exp_t       e;
    } cyc_t;

    typedef enum int {K_R, K_LD, K_ST, K_BR, K_J, K_IMM, K_ILL} kind_t;

    typedef struct {
        kind_t      kind;
        logic [1:0] size;
        bit         uns, zx, up, jal;
        logic [2:0] br;
        logic [3:0] aop;
    } desc_t;

    exp_t sb[$];
    cyc_t ins[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    // Instruction table by mnemonic.
    function automatic desc_t describe(input logic [5:0] op);
        desc_t d;
        d.kind = K_ILL; d.size = 2'b00; d.uns = 0; d.zx = 0; d.up = 0; d.jal = 0;
        d.br = 3'b000; d.aop = 4'h0;
        case (op)
            6'h00: d.kind = K_R;
            6'h20: begin d.kind = K_LD; d.size = 2'b00; end
            6'h21: begin d.kind = K_LD; d.size = 2'b01; end
            6'h23: begin d.kind = K_LD; d.size = 2'b10; end
            6'h24: begin d.kind = K_LD; d.size = 2'b00; d.uns = 1; end
            6'h25: begin d.kind = K_LD; d.size = 2'b01; d.uns = 1; end
            6'h28: begin d.kind = K_ST; d.size = 2'b00; end
            6'h29: begin d.kind = K_ST; d.size = 2'b01; end
            6'h2b: begin d.kind = K_ST; d.size = 2'b10; end
            6'h01: begin d.kind = K_BR; d.br = 3'b011; d.aop = 4'h0; end
            6'h04: begin d.kind = K_BR; d.br = 3'b001; d.aop = 4'h1; end
            6'h05: begin d.kind = K_BR; d.br = 3'b010; d.aop = 4'h1; end
            6'h06: begin d.kind = K_BR; d.br = 3'b100; d.aop = 4'h2; end
            6'h07: begin d.kind = K_BR; d.br = 3'b101; d.aop = 4'h3; end
            6'h02: d.kind = K_J;
            6'h03: begin d.kind = K_J; d.jal = 1; d.aop = 4'h2; end
            6'h08: begin d.kind = K_IMM; d.aop = 4'h4; end
            6'h09: begin d.kind = K_IMM; d.aop = 4'h4; d.uns = 1; end
            6'h0a: begin d.kind = K_IMM; d.aop = 4'h5; end
            6'h0b: begin d.kind = K_IMM; d.aop = 4'h5; d.uns = 1; end
            6'h0c: begin d.kind = K_IMM; d.aop = 4'h6; d.zx = 1; end
            6'h0d: begin d.kind = K_IMM; d.aop = 4'h7; d.zx = 1; end
            6'h0e: begin d.kind = K_IMM; d.aop = 4'h8; d.zx = 1; end
            6'h0f: begin d.kind = K_IMM; d.aop = 4'h8; d.up = 1; end
            default: ;
        endcase
        return d;
    endfunction

    function automatic exp_t st_only(input logic [3:0] st);
        exp_t e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t reset_word();
        exp_t e = '0;
        e.mem_req = 1'b1;
        e.srcb    = 2'b01;
        return e;
    endfunction

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int pick_wait();
        int r = int'($urandom_range(0, 19));
        if (r < 14)      return r % 4;
        else if (r < 17) return int'(TO) - 1;
        else             return int'($urandom_range(TO, TO + 4));
    endfunction

    task automatic add(input logic rdy, input logic [5:0] op, input exp_t e);
        cyc_t c;
        c.rst_n = 1'b1; c.rdy = rdy; c.op = op; c.e = e;
        ins.push_back(c);
    endtask

    // Memory wait: cycle k waits unless k==w (ready); the TO-th waiting cycle times out.
    task automatic mem_phase(input int w, input exp_t e_wait, input exp_t e_done,
                             input exp_t e_to, output bit ok);
        ok = 0;
        for (int k = 0; k < int'(TO) + 4; k++) begin
            if (k == w) begin
                add(1'b1, junk(), e_done);
                ok = 1;
                break;
            end else if (k == int'(TO) - 1) begin
                add(1'b0, junk(), e_to);
                break;
            end else begin
                add(1'b0, junk(), e_wait);
            end
        end
    endtask

    task automatic issue(input cyc_t c);
        rst_n     = c.rst_n;
        mem_ready = c.rdy;
        opcode    = c.op;
        sb.push_back(c.e);
        @(posedge clk);
        #1;
    endtask

    task automatic gen_instr(input logic [5:0] op, input int fw_in, input int mw,
                             input int abort_at);
        desc_t d = describe(op);
        exp_t  e, ew, ed, eto;
        bit    ok;
        int    fw = fw_in;
        cyc_t  rc;
        ins.delete();
        ok = 0;
        while (!ok) begin
            ew = st_only(4'd0); ew.mem_req = 1; ew.srcb = 2'b01;
            ed = ew; ed.irw = 1; ed.pcw = 1;
            eto = ew; eto.berr = 1;
            mem_phase(fw, ew, ed, eto, ok);
            fw = int'($urandom_range(0, 3));
        end
        e = st_only(4'd1); e.srcb = 2'b11;
        add(rbit(), op, e);
        case (d.kind)
            K_R: begin
                e = st_only(4'd6); e.srca = 1; e.aop = 4'hf; add(rbit(), junk(), e);
                e = st_only(4'd7); e.rw = 1; e.rdst = 2'b10; add(rbit(), junk(), e);
            end
            K_LD, K_ST: begin
                e = st_only(4'd2); e.srca = 1; e.srcb = 2'b10; add(rbit(), junk(), e);
                if (d.kind == K_LD) begin
                    ew = st_only(4'd3); ew.mem_req = 1; ew.iord = 1;
                    ew.msize = d.size; ew.uns = d.uns;
                    ed = ew; eto = ew; eto.berr = 1;
                    mem_phase(mw, ew, ed, eto, ok);
                    if (ok) begin
                        e = st_only(4'd4); e.rw = 1; e.m2r = 1;
                        e.msize = d.size; e.uns = d.uns;
                        add(rbit(), junk(), e);
                    end
                end else begin
                    ew = st_only(4'd5); ew.mem_req = 1; ew.iord = 1; ew.mw = 1;
                    ew.msize = d.size;
                    ed = ew; eto = ew; eto.mw = 0; eto.berr = 1;
                    mem_phase(mw, ew, ed, eto, ok);
                end
            end
            K_BR: begin
                e = st_only(4'd8); e.srca = 1; e.pcsrc = 2'b01; e.br = d.br; e.aop = d.aop;
                add(rbit(), junk(), e);
            end
            K_J: begin
                e = st_only(4'd9); e.pcw = 1; e.pcsrc = 2'b10;
                if (d.jal) begin e.rw = 1; e.rdst = 2'b10; e.ra = 1; e.aop = d.aop; end
                add(rbit(), junk(), e);
            end
            K_IMM: begin
                e = st_only(4'd10); e.srca = 1; e.srcb = 2'b10; e.aop = d.aop;
                e.zx = d.zx; e.uns = d.uns; e.up = d.up;
                add(rbit(), junk(), e);
                e.st = 4'd11; e.rw = 1;
                add(rbit(), junk(), e);
            end
            default: begin
                e = st_only(4'd12); e.ill = 1; add(rbit(), junk(), e);
            end
        endcase
        if (abort_at >= 0 && abort_at < ins.size()) begin
            while (ins.size() > abort_at) ins.delete(ins.size() - 1);
            rc.rst_n = 1'b0; rc.rdy = rbit(); rc.op = junk(); rc.e = reset_word();
            ins.push_back(rc);
        end
        foreach (ins[i]) issue(ins[i]);
    endtask

    always @(negedge clk) begin
        exp_t a, x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            a.st = state_dbg; a.mem_req = mem_req; a.iord = IorD; a.irw = IRWrite;
            a.pcw = PCWrite; a.pcsrc = PCSrc; a.srca = ALUSrcA; a.srcb = ALUSrcB;
            a.aop = ALUOp; a.rw = RegWrite; a.mw = MemWrite; a.m2r = MemToReg;
            a.zx = zero_extended; a.uns = unsigned_ALU_op; a.up = immediate_to_upper_reg;
            a.ra = PC_to_ra_reg; a.rdst = RegDst; a.msize = MEM_size; a.br = Branch;
            a.ill = illegal_op; a.berr = bus_error;
            checks++;
            if (a !== x) begin
                errors++;
                $display("FAIL ctrl_word cycle=%0d: got state=%0d word=%h, expected state=%0d word=%h",
                         cyc_no, a.st, a, x.st, x);
            end
            cyc_no++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
        $fatal(1);
    end

    localparam int NV = 23;
    logic [5:0] valid_ops [NV] = '{6'h00, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29,
                                   6'h2b, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03,
                                   6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e};

    initial begin
        cyc_t rc;
        logic [5:0] op;
        @(posedge clk);
        #1;
        rc.rst_n = 1'b0; rc.rdy = 1'b0; rc.op = 6'd0; rc.e = reset_word();
        issue(rc);
        issue(rc);
        gen_instr(6'h00, 0, 0, -1);
        gen_instr(6'h23, 0, 2, -1);
        gen_instr(6'h2b, 0, 30, -1);
        gen_instr(6'h3f, 0, 0, -1);
        gen_instr(6'h07, 0, 0, -1);
        gen_instr(6'h01, 0, 0, -1);
        gen_instr(6'h03, 0, 0, -1);
        gen_instr(6'h0f, 0, 0, -1);
        gen_instr(6'h2b, 0, 30, 5);
        gen_instr(6'h2b, 0, 30, -1);
        gen_instr(6'h00, 15, 0, -1);
        gen_instr(6'h00, 16, 0, -1);
        gen_instr(6'h23, 1, 15, -1);
        gen_instr(6'h21, 0, 16, -1);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 5) == 0) op = junk();
            else op = valid_ops[$urandom_range(0, NV - 1)];
            gen_instr(op, pick_wait(), pick_wait(),
                      ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 12)) : -1);
        end
        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
